// File: rtl/data_mem_mmio.sv
// Data memory with lane alignment plus MMIO console TX FIFO and status flags.
// Optional cycle counter is built when DMEM_CYCLE_CNT_EN is defined.
module data_mem_mmio #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00,
  parameter int unsigned TX_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  logic [63:0] mem [DEPTH_WORDS];

  logic          mmio_sel;
  logic          in_range;
  logic [2:0]    off;
  logic [7:0]    moff;
  logic [AW-1:0] idx;
  logic [15:0]   emask16;
  logic [63:0]   edata;
  logic          ram_we;

  assign mmio_sel = addr[31:8] == MMIO_BASE[31:8];
  assign in_range = addr[31:3] < 29'(DEPTH_WORDS);
  assign off      = addr[2:0];
  assign moff     = addr[7:0];
  assign idx      = addr[AW+2:3];
  assign emask16  = {8'h00, wmask} << off;
  assign edata    = wdata << {off, 3'b000};
  assign ram_we   = wr_en && !rst && !mmio_sel && in_range;

  // Bytes shifted past lane 7 are simply dropped.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 8; b++) begin
        if (emask16[b]) mem[idx][8*b +: 8] <= edata[8*b +: 8];
      end
    end
  end

  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          mis_q, mis_d;
  logic          rng_q, rng_d;

  logic tx_wr, st_wr, full, empty, pop, push;
  logic ovf_set, mis_set, rng_set;
  logic [2:0] clr;

  assign tx_wr   = wr_en && mmio_sel && moff == 8'h00 && wmask[0];
  assign st_wr   = wr_en && mmio_sel && moff == 8'h08 && wmask[0];
  assign full    = cnt_q == CW'(TX_DEPTH);
  assign empty   = cnt_q == '0;
  assign pop     = tx_valid && tx_ready;
  assign push    = tx_wr && (!full || pop);
  assign ovf_set = tx_wr && full && !pop;
  assign mis_set = wr_en && !mmio_sel && in_range && |emask16[15:8];
  assign rng_set = wr_en && !mmio_sel && !in_range;
  assign clr     = st_wr ? wdata[4:2] : 3'b000;

  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A set in the same cycle as a clear wins.
    ovf_d = (ovf_q & ~clr[0]) | ovf_set;
    mis_d = (mis_q & ~clr[1]) | mis_set;
    rng_d = (rng_q & ~clr[2]) | rng_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      mis_q  <= 1'b0;
      rng_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      mis_q  <= mis_d;
      rng_q  <= rng_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_q[wptr_q] <= wdata[7:0];
  end

  logic [63:0] cyc;
`ifdef DMEM_CYCLE_CNT_EN
  logic [63:0] cyc_q;
  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_q + 64'd1;
  end
  assign cyc = cyc_q;
`else
  assign cyc = '0;
`endif

  logic [63:0] status;
  assign status = {48'h0, 8'(cnt_q), 3'b000,
                   rng_q, mis_q, ovf_q, full, empty};

  always_comb begin
    rdata = '0;
    if (mmio_sel) begin
      unique case (moff)
        8'h08:   rdata = status;
        8'h10:   rdata = cyc;
        default: rdata = '0;
      endcase
    end else if (in_range) begin
      rdata = mem[idx] >> {off, 3'b000};
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: vector table for RAM/STATUS,
// scoreboard queue for the TX FIFO drain port.
module tb_data_mem_mmio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wmask = '0;
  logic [63:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  localparam logic [31:0] MB = 32'hFFFF_FF00;
`ifdef DMEM_CYCLE_CNT_EN
  localparam logic [63:0] CNT_ON = 64'd1;
`else
  localparam logic [63:0] CNT_ON = 64'd0;
`endif

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_q[$];

  data_mem_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .wmask    (wmask),
    .rdata    (rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    logic        chk;
    logic [63:0] e;
    string       nm;
  } vec_t;

  function automatic vec_t mkv(input logic w, input logic [31:0] a,
                               input logic [63:0] d, input logic [7:0] m,
                               input logic chk, input logic [63:0] e,
                               input string nm);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.m = m;
    v.chk = chk; v.e = e; v.nm = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic op(input logic w, input logic [31:0] a,
                    input logic [63:0] d, input logic [7:0] m,
                    input logic rdy);
    @(posedge clk);
    #1;
    wr_en = w; addr = a; wdata = d; wmask = m; tx_ready = rdy;
  endtask

  task automatic ld(input string nm, input logic [31:0] a,
                    input logic [63:0] e);
    op(1'b0, a, 64'h0, 8'h00, 1'b0);
    @(negedge clk);
    check(nm, rdata, e);
  endtask

  task automatic idle(input logic rdy);
    op(1'b0, 32'h0, 64'h0, 8'h00, rdy);
  endtask

  task automatic push(input logic [7:0] b, input logic acc,
                      input logic rdy);
    op(1'b1, MB, {56'h0, b}, 8'h01, rdy);
    if (acc) exp_q.push_back(b);
  endtask

  // Scoreboard: every accepted head byte must match the oldest push.
  always @(negedge clk) begin
    if (!rst && tx_valid === 1'b1 && tx_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL tx_pop: got %h expected none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          failed++;
          $display("FAIL tx_pop: got %h expected %h", tx_data, e);
        end
      end
    end
  end

  vec_t tbl[$];

  initial begin
    tbl.push_back(mkv(1, 32'h0, 64'h0123456789ABCDEF, 8'hFF, 0, 0, "sd0"));
    tbl.push_back(mkv(1, 32'h40, 64'h1122334455667788, 8'hFF, 0, 0, "sd40"));
    tbl.push_back(mkv(1, 32'h44, 64'hAABBCCDD, 8'h0F, 0, 0, "sw44"));
    tbl.push_back(mkv(0, 32'h40, 0, 0, 1, 64'hAABBCCDD55667788, "ld40"));
    tbl.push_back(mkv(0, 32'h44, 0, 0, 1, 64'h00000000AABBCCDD, "ld44"));
    tbl.push_back(mkv(0, 32'h42, 0, 0, 1, 64'h0000AABBCCDD5566, "ld42"));
    tbl.push_back(mkv(1, 32'h41, 64'hBEEF, 8'h03, 0, 0, "sh41"));
    tbl.push_back(mkv(0, 32'h40, 0, 0, 1, 64'hAABBCCDD55BEEF88, "ld40_sh"));
    tbl.push_back(mkv(0, 32'h47, 0, 0, 1, 64'h00000000000000AA, "ld47"));
    tbl.push_back(mkv(0, MB + 8, 0, 0, 1, 64'h1, "st_clean"));
    tbl.push_back(mkv(1, 32'h46, 64'hAABBCCDD, 8'h0F, 0, 0, "sw46"));
    tbl.push_back(mkv(0, 32'h40, 0, 0, 1, 64'hCCDDCCDD55BEEF88, "ld40_mis"));
    tbl.push_back(mkv(0, MB + 8, 0, 0, 1, 64'h9, "st_mis"));
    tbl.push_back(mkv(1, MB + 8, 64'h08, 8'h01, 0, 0, "clr_mis"));
    tbl.push_back(mkv(0, MB + 8, 0, 0, 1, 64'h1, "st_mis_clr"));
    tbl.push_back(mkv(1, 32'h2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 0, "sd_oor"));
    tbl.push_back(mkv(0, MB + 8, 0, 0, 1, 64'h11, "st_rng"));
    tbl.push_back(mkv(0, 32'h2000, 0, 0, 1, 64'h0, "ld_oor"));
    tbl.push_back(mkv(0, 32'h0, 0, 0, 1, 64'h0123456789ABCDEF, "ld0_kept"));
    tbl.push_back(mkv(1, MB + 8, 64'h10, 8'h02, 0, 0, "clr_nomask"));
    tbl.push_back(mkv(0, MB + 8, 0, 0, 1, 64'h11, "st_rng_kept"));
    tbl.push_back(mkv(1, MB + 8, 64'h10, 8'h01, 0, 0, "clr_rng"));
    tbl.push_back(mkv(0, MB + 8, 0, 0, 1, 64'h1, "st_rng_clr"));
    tbl.push_back(mkv(0, MB, 0, 0, 1, 64'h0, "rd_txdata"));
    tbl.push_back(mkv(1, MB + 8'h18, 64'hFF, 8'hFF, 0, 0, "st_other"));
    tbl.push_back(mkv(0, MB + 8'h18, 0, 0, 1, 64'h0, "rd_other"));
    tbl.push_back(mkv(0, MB + 8, 0, 0, 1, 64'h1, "st_after_other"));

    // Reset, then cycle counter five edges after release.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ld("rst_status", MB + 8, 64'h1);
    check("rst_txv", {63'h0, tx_valid}, 64'h0);
    ld("rst_txdata", MB, 64'h0);
    idle(1'b0);
    idle(1'b0);
    ld("cycle5", MB + 8'h10, 64'd5 * CNT_ON);
    ld("cycle6", MB + 8'h10, 64'd6 * CNT_ON);

    foreach (tbl[i]) begin
      op(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, 1'b0);
      if (tbl[i].chk) begin
        @(negedge clk);
        check(tbl[i].nm, rdata, tbl[i].e);
      end
    end

    // Two pushes held, then drained.
    push(8'h41, 1'b1, 1'b0);
    push(8'h42, 1'b1, 1'b0);
    ld("fifo2_status", MB + 8, 64'h0200);
    check("fifo2_txv", {63'h0, tx_valid}, 64'h1);
    check("fifo2_head", {56'h0, tx_data}, 64'h41);
    idle(1'b1);
    idle(1'b1);
    ld("drained", MB + 8, 64'h1);
    check("drained_txv", {63'h0, tx_valid}, 64'h0);

    // Fill to full, ninth push overflows.
    for (int i = 0; i < 9; i++) push(8'(8'h50 + i), i < 8, 1'b0);
    ld("ovf_status", MB + 8, 64'h0806);
    check("ovf_head", {56'h0, tx_data}, 64'h50);
    op(1'b1, MB + 8, 64'h04, 8'h01, 1'b0);
    ld("ovf_clr", MB + 8, 64'h0802);
    push(8'h59, 1'b1, 1'b1);
    ld("full_push", MB + 8, 64'h0802);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    ld("cnt5", MB + 8, 64'h0500);
    op(1'b1, 32'h41, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0);
    ld("pre_rst", MB + 8, 64'h0508);

    // Reset mid-stream with a RAM store in the same cycle.
    op(1'b1, 32'h0, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; addr = MB + 8;
    @(negedge clk);
    check("mid_rst_status", rdata, 64'h1);
    check("mid_rst_txv", {63'h0, tx_valid}, 64'h0);
    ld("rst_blocks_store", 32'h0, 64'h0123456789ABCDEF);
    push(8'h61, 1'b1, 1'b0);
    ld("post_rst_push", MB + 8, 64'h0100);
    check("post_rst_head", {56'h0, tx_data}, 64'h61);
    idle(1'b1);
    ld("post_rst_empty", MB + 8, 64'h1);
    check("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory subsystem sitting directly downstream of the single-cycle RV64 core's data port. It takes the core's byte address, write enable, write data and unshifted byte mask, and returns load data in the same cycle. Lane alignment is done here, and the returned data is right-justified so the core's sign/zero-extension works unchanged. A small MMIO window adds a console TX byte FIFO with a valid/ready drain port, sticky error flags, and an optional 64-bit cycle counter.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 64-bit words; power of two.
- MMIO_BASE, 32'hFFFF_FF00: base of the 256-byte MMIO window; 256-byte aligned.
- TX_DEPTH, 8: TX FIFO depth in bytes; power of two, at least 2.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the core.
- wr_en  in  1  store strobe, sampled at the rising edge.
- wdata  in  64  store data, right-justified.
- wmask  in  8  byte mask, right-justified: SD 8'hFF, SW 8'h0F, SH 8'h03.
- rdata  out  64  load data, combinational, right-justified.
- tx_valid  out  1  FIFO non-empty.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts the head byte.

## Operation
- Decode:
  - addr[31:8]==MMIO_BASE[31:8] selects MMIO.
  - Otherwise, RAM word index is addr[31:3] and lane offset is off=addr[2:0].
  - A RAM access is in range when index < DEPTH_WORDS.
- RAM store, in range:
  - Effective mask is (wmask<<off) truncated to 8 bits.
  - Effective data is wdata<<(8*off).
  - Only bytes with their mask bit set are written.
  - If any set bit of wmask is shifted out of the 8-bit mask, set sticky MISALIGN; the shifted-out bytes are dropped.
- RAM store, out of range: no write; set sticky RANGE.
- RAM load: rdata = word>>(8*off), upper bytes zero-filled. Out-of-range loads return 0 and do not set flags (the core issues speculative reads).
- RAM contents are not reset.
- MMIO registers (offset = addr[7:0]):
  - 0x00 TXDATA: a store with wmask[0]=1 pushes wdata[7:0]. Reads return 0.
  - 0x08 STATUS: read-only fields:
    - [0] empty, [1] full, [2] OVERFLOW, [3] MISALIGN, [4] RANGE.
    - [15:8] FIFO count, zero-extended.
    - Other bits read 0.
    - A store with wmask[0]=1 clears each sticky bit [4:2] whose wdata bit is 1.
  - 0x10 CYCLE: cycle counter, read-only; stores ignored.
  - Any other offset reads 0; stores to it are ignored.
- TX FIFO:
  - Push when a TXDATA store occurs and (count<TX_DEPTH or a pop occurs in the same cycle).
  - A push to a full FIFO with no pop is dropped and sets OVERFLOW.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop keeps count unchanged.
  - Read and write pointers wrap modulo TX_DEPTH.
- A sticky-bit set and a clear in the same cycle: the set wins.

## Timing
- Loads are zero-latency: rdata is combinational from addr and the current state.
- Stores take effect at the rising edge where wr_en=1 and are visible to a load in the next cycle.
- A store followed by a load to the same address in the next cycle returns the new data (no bypass needed).
- A TXDATA push is reflected in tx_valid/tx_data in the following cycle.
- tx_data is stable while tx_valid && !tx_ready.
- Reset values, applied at the first edge with rst=1:
  - tx_valid=0, FIFO count 0, pointers 0.
  - Sticky flags 0, cycle counter 0.
  - rdata is whatever combinational function of addr results.
- Assertion of rst mid-stream discards FIFO contents and blocks all stores in that cycle.

## Configuration
- DMEM_CYCLE_CNT_EN defined:
  - 64-bit counter reset to 0, incrementing by 1 every non-reset cycle.
  - Wraps from 2^64-1 to 0.
  - CYCLE reads the pre-edge value.
- Not defined: no counter register is built and CYCLE reads 0.

## Test plan
- Store SD 0x1122334455667788 @0x40, then SW wdata=0xAABBCCDD mask 0x0F @0x44 -> load @0x40 returns 0xAABBCCDD55667788; load @0x44 returns 0x00000000AABBCCDD.
- SW mask 0x0F @0x46 -> bytes 6,7 of word 8 become DD,CC; STATUS[3]=1. Store 0x08 to STATUS with mask 0x01 -> STATUS[3]=0.
- Push 0x41,0x42 with tx_ready=0 -> tx_valid=1, tx_data=0x41, STATUS[15:8]=2. Raise tx_ready -> 0x41 then 0x42 accepted; empty after 2 cycles.
- With TX_DEPTH=8, push 9 bytes with tx_ready=0 -> 9th dropped, STATUS=0x0806. Push while full with tx_ready=1 -> accepted, count stays 8, no new overflow.
- Store to DEPTH_WORDS*8 -> STATUS[4]=1, RAM unchanged. Assert rst mid-FIFO -> tx_valid=0 and STATUS=0x0001 next cycle.
- With DMEM_CYCLE_CNT_EN: release reset, read CYCLE 5 cycles later -> 5. Without the macro -> 0.
